// File: rtl/alu_param_if.sv
// alu_param_if: command/result bundle between the ALU and its driver.
// master drives commands and reads results; slave is the ALU side.
interface alu_param_if #(
    parameter int WIDTH = 8
);
    logic             alu_enable;
    logic             alu_enable_a;
    logic             alu_enable_b;
    logic [2:0]       alu_op_a;
    logic [1:0]       alu_op_b;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic             alu_irq_clr;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_out_hi;
    logic             alu_out_valid;
    logic             alu_busy;
    logic             alu_irq;
    logic [2:0]       alu_irq_status;

    modport master (
        output alu_enable, alu_enable_a, alu_enable_b,
        output alu_op_a, alu_op_b, alu_in_a, alu_in_b,
        output alu_irq_clr,
        input  alu_out, alu_out_hi, alu_out_valid,
        input  alu_busy, alu_irq, alu_irq_status
    );

    modport slave (
        input  alu_enable, alu_enable_a, alu_enable_b,
        input  alu_op_a, alu_op_b, alu_in_a, alu_in_b,
        input  alu_irq_clr,
        output alu_out, alu_out_hi, alu_out_valid,
        output alu_busy, alu_irq, alu_irq_status
    );
endinterface

// File: rtl/alu_param.sv
// alu_param: parametrised two-mode ALU with registered results, iterative
// shift-add multiplier (busy while running) and sticky irq status.
// Ports: alu_clk, alu_rst (sync, active-high), bus (alu_param_if.slave):
//   commands alu_enable/_a/_b, alu_op_a/_b, alu_in_a/_b, alu_irq_clr;
//   results alu_out, alu_out_hi, alu_out_valid, alu_busy, alu_irq,
//   alu_irq_status ([0] carry/borrow, [1] MUL hi nonzero, [2] illegal).
// Optional: define ALU_SAT_EN to saturate mode A ADD/SUB instead of wrap.
module alu_param #(
    parameter int WIDTH = 8
) (
    input logic        alu_clk,
    input logic        alu_rst,
    alu_param_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic             valid_q, valid_d;
    logic [2:0]       status_q, status_d;
    logic             irq_q, irq_d;

    logic             illegal;
    logic             acc_a;
    logic             acc_b;
    logic [2:0]       set;
    logic [WIDTH:0]   add_full;
    logic             borrow;
    logic [WIDTH-1:0] sub_res;
    logic [31:0]      shamt;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        valid_d  = 1'b0;
        set      = 3'b000;

        illegal = bus.alu_enable & bus.alu_enable_a & bus.alu_enable_b;
        acc_a   = bus.alu_enable & bus.alu_enable_a & ~bus.alu_enable_b;
        acc_b   = bus.alu_enable & ~bus.alu_enable_a & bus.alu_enable_b;

        add_full = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b};
        borrow   = bus.alu_in_a < bus.alu_in_b;
        sub_res  = bus.alu_in_a - bus.alu_in_b;
        shamt    = 32'(bus.alu_in_b) % 32'(WIDTH);

        // One shift-add step: conditionally add the multiplicand into the
        // high half, then shift the whole {carry, hi, lo} right by one.
        step_sum = {1'b0, acc_hi_q}
                 + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], acc_lo_q[WIDTH-1:1]};

        unique case (state_q)
            ST_IDLE: begin
                unique case (1'b1)
                    illegal: set[2] = 1'b1;
                    acc_a: begin
                        valid_d  = 1'b1;
                        out_hi_d = '0;
                        unique case (bus.alu_op_a)
                            3'd0: begin
                                set[0] = add_full[WIDTH];
`ifdef ALU_SAT_EN
                                out_d = add_full[WIDTH] ? '1
                                      : add_full[WIDTH-1:0];
`else
                                out_d = add_full[WIDTH-1:0];
`endif
                            end
                            3'd1: begin
                                set[0] = borrow;
`ifdef ALU_SAT_EN
                                out_d = borrow ? '0 : sub_res;
`else
                                out_d = sub_res;
`endif
                            end
                            3'd2: out_d = bus.alu_in_a & bus.alu_in_b;
                            3'd3: out_d = bus.alu_in_a | bus.alu_in_b;
                            3'd4: out_d = bus.alu_in_a ^ bus.alu_in_b;
                            3'd5: out_d = ~bus.alu_in_a;
                            3'd6: out_d = bus.alu_in_a << shamt;
                            3'd7: out_d = bus.alu_in_a >> shamt;
                        endcase
                    end
                    acc_b: begin
                        unique case (bus.alu_op_b)
                            2'd0: begin
                                state_d  = ST_MUL;
                                cnt_d    = '0;
                                mcand_d  = bus.alu_in_a;
                                acc_hi_d = '0;
                                acc_lo_d = bus.alu_in_b;
                            end
                            2'd1: begin
                                valid_d  = 1'b1;
                                out_hi_d = '0;
                                out_d    = ~(bus.alu_in_a & bus.alu_in_b);
                            end
                            2'd2: begin
                                valid_d  = 1'b1;
                                out_hi_d = '0;
                                out_d    = ~(bus.alu_in_a | bus.alu_in_b);
                            end
                            2'd3: begin
                                valid_d  = 1'b1;
                                out_hi_d = '0;
                                out_d    = ~(bus.alu_in_a ^ bus.alu_in_b);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_MUL: begin
                // Commands are ignored here, including illegal mode.
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = ST_IDLE;
                    out_d    = step_lo;
                    out_hi_d = step_hi;
                    valid_d  = 1'b1;
                    set[1]   = |step_hi;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A bit set this cycle survives a simultaneous clear.
        status_d = (bus.alu_irq_clr ? 3'b000 : status_q) | set;
        irq_d    = |status_d;
    end

    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            valid_q  <= 1'b0;
            status_q <= 3'b000;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            valid_q  <= valid_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.alu_out        = out_q;
    assign bus.alu_out_hi     = out_hi_q;
    assign bus.alu_out_valid  = valid_q;
    assign bus.alu_busy       = (state_q == ST_MUL);
    assign bus.alu_irq        = irq_q;
    assign bus.alu_irq_status = status_q;

endmodule
